ipsxb_baud_gen_frac: RTL and testbench

//  Parametrised fractional baud-tick generator; successor to the UART clock-enable divider.

---
 rtl/ipsxb_baud_gen_frac.sv | 82 ++++++++
 tb/tb_ipsxb_baud_gen_frac.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ipsxb_baud_gen_frac.sv
// ipsxb_baud_gen_frac: fractional baud-tick generator producing oversample, mid-bit and bit ticks
//   clk, rst              system clock, async active-high reset
//   en                    enable; low holds counters idle and applies any pending divisor
//   div_int, div_frac     new divisor, captured on div_load
//   div_load              capture pulse; applied at the next bit boundary, sync, or while idle
//   sync                  re-phase: clears cnt, ph and fractional accumulator
//   ovs_tick              one pulse per oversample period
//   mid_tick, bit_tick    pulses at oversample events OVS/2 and OVS of each bit
//   cfg_err               active integer divisor is zero (clamped to 1)
module ipsxb_baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int DEF_DIV_INT  = 27,
    parameter int DEF_DIV_FRAC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              sync,
    output logic              ovs_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);
    localparam int PH_W = $clog2(OVS);
    localparam logic [DIV_W:0] ONE = 1;
    logic [DIV_W:0]    cnt, d_eff, period;
    logic [PH_W-1:0]   ph;
    logic [FRAC_W-1:0] frac_acc, act_frac, pend_frac, src_frac;
    logic [DIV_W-1:0]  act_int, pend_int, src_int;
    logic              extra, pend_vld, idle, ev, bnd, apply;
    always_comb begin
        d_eff    = (act_int == '0) ? ONE : {1'b0, act_int};
        period   = d_eff + {{DIV_W{1'b0}}, extra};
        idle     = !en || sync;
        ev       = !idle && (cnt == period - ONE);
        bnd      = ev && (ph == PH_W'(OVS - 1));
        // a load coinciding with the apply point takes effect immediately
        apply    = (pend_vld || div_load) && (idle || bnd);
        src_int  = div_load ? div_int : pend_int;
        src_frac = div_load ? div_frac : pend_frac;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ph        <= '0;
            frac_acc  <= '0;
            extra     <= 1'b0;
            act_int   <= DIV_W'(DEF_DIV_INT);
            act_frac  <= FRAC_W'(DEF_DIV_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
            pend_vld  <= 1'b0;
            ovs_tick  <= 1'b0;
            mid_tick  <= 1'b0;
            bit_tick  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cnt      <= (idle || ev) ? '0 : cnt + ONE;
            ph       <= idle ? '0 : ev ? (bnd ? '0 : ph + 1'b1) : ph;
            // the carry out of the fractional add stretches the following period by one cycle
            {extra, frac_acc} <= idle ? '0 : ev ? {1'b0, frac_acc} + {1'b0, act_frac} : {extra, frac_acc};
            if (div_load) begin
                pend_int  <= div_int;
                pend_frac <= div_frac;
            end
            pend_vld <= apply ? 1'b0 : (div_load || pend_vld);
            if (apply) begin
                act_int  <= src_int;
                act_frac <= src_frac;
            end
            ovs_tick <= ev;
            mid_tick <= ev && (ph == PH_W'(OVS / 2 - 1));
            bit_tick <= bnd;
            cfg_err  <= (act_int == '0);
        end
    end
endmodule

// File: tb/tb_ipsxb_baud_gen_frac.sv
// tb_ipsxb_baud_gen_frac: directed table-driven bench for the fractional baud-tick generator
module tb_ipsxb_baud_gen_frac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        sync = 1'b0;
    logic        ovs_tick, mid_tick, bit_tick, cfg_err;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int   d_int;
        int   d_frac;
        logic err;
        int   first;
        int   mid;
        int   bt;
        int   span;
    } vec_t;
    vec_t tbl[5];

    ipsxb_baud_gen_frac dut (
        .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .sync(sync), .ovs_tick(ovs_tick), .mid_tick(mid_tick),
        .bit_tick(bit_tick), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
    endtask

    // edges counted from the first enabled edge; -1 marks an expired bound
    task automatic measure(output int f, output int m, output int b, output int s);
        int n;
        f = -1; m = -1; b = -1; s = -1; n = 0;
        for (int c = 1; c <= 1200 && s < 0; c++) begin
            step();
            if (ovs_tick) begin
                n++;
                if (n == 1) f = c;
                if (n == 33) s = c - f;
            end
            if (mid_tick && m < 0) m = c;
            if (bit_tick && b < 0) b = c;
        end
    endtask

    task automatic wait_tick(input int sel, output int n);
        logic hit;
        n = -1;
        for (int c = 1; c <= 500; c++) begin
            step();
            hit = (sel == 0) ? ovs_tick : (sel == 1) ? mid_tick : bit_tick;
            if (hit) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int f, m, b, s, n;
        tbl[0] = '{3, 0, 1'b0, 3, 24, 48, 96};
        tbl[1] = '{4, 8, 1'b0, 4, 35, 71, 144};
        tbl[2] = '{0, 0, 1'b1, 1, 8, 16, 32};
        tbl[3] = '{2, 15, 1'b0, 2, 22, 46, 94};
        tbl[4] = '{5, 3, 1'b0, 5, 41, 82, 166};

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_ovs", int'(ovs_tick), 0);
        chk("rst_mid", int'(mid_tick), 0);
        chk("rst_bit", int'(bit_tick), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);

        en = 1'b1;
        measure(f, m, b, s);
        chk("def_first", f, 27);
        chk("def_mid", m, 216);
        chk("def_bit", b, 432);
        chk("def_span", s, 864);
        en = 1'b0;
        step();

        foreach (tbl[i]) begin
            load(tbl[i].d_int, tbl[i].d_frac);
            chk($sformatf("v%0d_cfg_err", i), int'(cfg_err), int'(tbl[i].err));
            en = 1'b1;
            measure(f, m, b, s);
            chk($sformatf("v%0d_first", i), f, tbl[i].first);
            chk($sformatf("v%0d_mid", i), m, tbl[i].mid);
            chk($sformatf("v%0d_bit", i), b, tbl[i].bt);
            chk($sformatf("v%0d_span", i), s, tbl[i].span);
            en = 1'b0;
            step();
        end

        // reload mid-bit: old divisor finishes the bit, new one governs the next
        load(3, 0);
        en = 1'b1;
        wait_tick(1, n);
        chk("t3_mid", n, 24);
        div_int = 16'd5;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_tick(2, n);
        chk("t3_bit", n + 1, 24);
        wait_tick(0, n);
        chk("t3_new_ovs", n, 5);
        wait_tick(2, n);
        chk("t3_next_bit", n, 75);
        en = 1'b0;
        step();

        // sync on the cycle that would otherwise be an ovs event, with ph=5
        load(3, 0);
        en = 1'b1;
        repeat (5) wait_tick(0, n);
        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t4_no_tick", int'(ovs_tick), 0);
        wait_tick(1, n);
        chk("t4_mid", n, 24);
        wait_tick(2, n);
        chk("t4_bit", n, 24);
        en = 1'b0;
        step();

        // reset mid-bit discards a pending divisor
        load(3, 0);
        en = 1'b1;
        wait_tick(1, n);
        div_int = 16'd5;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_tick(0, n);
        chk("t6_ovs_before", int'(ovs_tick), 1);
        rst = 1'b1;
        #1;
        chk("t6_outs_async", int'({ovs_tick, mid_tick, bit_tick, cfg_err}), 0);
        step();
        rst = 1'b0;
        wait_tick(0, n);
        chk("t6_first", n, 27);
        wait_tick(0, n);
        chk("t6_second", n, 27);
        repeat (25) wait_tick(0, n);
        chk("t6_late", n, 27);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
